// File: rtl/arith_accum_pkg.sv
// arith_accum_pkg: mode encoding and default widths shared by the arithmetic accumulator block
package arith_accum_pkg;
    typedef enum logic [1:0] {
        MODE_ADD    = 2'd0,
        MODE_SUB    = 2'd1,
        MODE_SATADD = 2'd2,
        MODE_ACC    = 2'd3
    } mode_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 8;
endpackage

// File: rtl/arith_accum_if.sv
// arith_accum_if: operand/result valid-ready bus between a producer (master) and the unit (slave)
interface arith_accum_if import arith_accum_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    mode_t                mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] result;
    logic                 ovf;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, ovf
    );
    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/arith_accum_alu.sv
// arith_accum_alu: combinational add/sub/saturating-add/accumulate datapath with overflow detect
module arith_accum_alu import arith_accum_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  mode_t                i_mode,
    input  logic [ACC_WIDTH-1:0] i_acc,
    output logic [ACC_WIDTH-1:0] o_result,
    output logic                 o_ovf
);
    logic [WIDTH:0]       w_sum;
    logic [ACC_WIDTH:0]   w_acc_sum;
    logic [ACC_WIDTH-1:0] w_sub;
    logic [ACC_WIDTH-1:0] w_sat;

    assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
    assign w_acc_sum = {1'b0, i_acc} + (ACC_WIDTH+1)'(w_sum);
    assign w_sub     = ACC_WIDTH'(i_a) - ACC_WIDTH'(i_b);
    // carry out of the operand width is exactly the saturation condition
    assign w_sat     = w_sum[WIDTH] ? ACC_WIDTH'({WIDTH{1'b1}}) : ACC_WIDTH'(w_sum);

    always_comb begin
        o_result = i_mode == MODE_ADD    ? ACC_WIDTH'(w_sum) :
                   i_mode == MODE_SUB    ? w_sub :
                   i_mode == MODE_SATADD ? w_sat : w_acc_sum[ACC_WIDTH-1:0];
        o_ovf    = i_mode == MODE_SUB    ? (i_a < i_b) :
                   i_mode == MODE_SATADD ? w_sum[WIDTH] :
                   i_mode == MODE_ACC    ? w_acc_sum[ACC_WIDTH] : 1'b0;
    end
endmodule

// File: rtl/arith_accum_unit.sv
// arith_accum_unit: registered arithmetic unit with valid/ready backpressure, accumulator,
// sticky overflow and transaction counter
module arith_accum_unit import arith_accum_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr_acc,
    output logic                 o_sticky_ovf,
    output logic [CNT_WIDTH-1:0] o_op_count,
    arith_accum_if.slave         bus
);
    if (ACC_WIDTH < WIDTH + 1) begin : g_bad_width
        $error("arith_accum_unit: ACC_WIDTH must be at least WIDTH+1");
    end

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_result;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic                 r_sticky;
    logic [CNT_WIDTH-1:0] r_op_count;
    logic                 w_accept;
    logic [ACC_WIDTH-1:0] w_acc_cur;
    logic [ACC_WIDTH-1:0] w_alu_result;
    logic                 w_alu_ovf;

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign w_accept      = bus.in_valid && bus.in_ready;
    // a clear in the same cycle as an ACC accept makes that accept start from zero
    assign w_acc_cur     = i_clr_acc ? '0 : r_acc;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign o_sticky_ovf  = r_sticky;
    assign o_op_count    = r_op_count;

    arith_accum_alu #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_alu (
        .i_a      (bus.a),
        .i_b      (bus.b),
        .i_mode   (bus.mode),
        .i_acc    (w_acc_cur),
        .o_result (w_alu_result),
        .o_ovf    (w_alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_sticky    <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_result   <= w_alu_result;
                r_ovf      <= w_alu_ovf;
                r_op_count <= r_op_count + CNT_WIDTH'(1);
            end
            if (w_accept && bus.mode == MODE_ACC) r_acc <= w_alu_result;
            else if (i_clr_acc) r_acc <= '0;
            r_out_valid <= w_accept || (r_out_valid && !bus.out_ready);
            // a new overflow wins over a simultaneous clear
            r_sticky    <= (w_accept && w_alu_ovf) || (r_sticky && !i_clr_acc);
        end
    end
endmodule

// File: tb/tb_arith_accum_unit.sv
// tb_arith_accum_unit: directed vectors into a default and a 9-bit-accumulator instance,
// scoreboard queues checked by per-instance output monitors
module tb_arith_accum_unit;
    import arith_accum_pkg::*;

    typedef struct {
        logic [15:0] r;
        logic        o;
        logic        s;
        logic [7:0]  c;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       clr1, clr2;
    logic       sticky1, sticky2;
    logic [7:0] cnt1, cnt2;
    logic [7:0] exp_cnt1, exp_cnt2;
    exp_t       q1[$];
    exp_t       q2[$];
    exp_t       e1, e2;
    int         n_checks;
    int         n_fail;

    arith_accum_if #(.WIDTH(8), .ACC_WIDTH(16)) bus1 ();
    arith_accum_if #(.WIDTH(8), .ACC_WIDTH(9))  bus2 ();

    arith_accum_unit #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_clr_acc(clr1),
        .o_sticky_ovf(sticky1), .o_op_count(cnt1), .bus(bus1)
    );
    arith_accum_unit #(.WIDTH(8), .ACC_WIDTH(9), .CNT_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_clr_acc(clr2),
        .o_sticky_ovf(sticky2), .o_op_count(cnt2), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            chk("u1_pending", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("u1_result", 32'(bus1.result), 32'(e1.r));
                chk("u1_ovf", 32'(bus1.ovf), 32'(e1.o));
                chk("u1_sticky", 32'(sticky1), 32'(e1.s));
                chk("u1_count", 32'(cnt1), 32'(e1.c));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus2.out_valid && bus2.out_ready) begin
            chk("u2_pending", 32'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                chk("u2_result", 32'(bus2.result), 32'(e2.r));
                chk("u2_ovf", 32'(bus2.ovf), 32'(e2.o));
                chk("u2_sticky", 32'(sticky2), 32'(e2.s));
                chk("u2_count", 32'(cnt2), 32'(e2.c));
            end
        end
    end

    task automatic issue1(input logic [7:0] ta, input logic [7:0] tb, input mode_t tm, input logic tc,
                          input logic [15:0] er, input logic eo, input logic es);
        chk("u1_in_ready", 32'(bus1.in_ready), 1);
        bus1.in_valid = 1'b1;
        bus1.a = ta;
        bus1.b = tb;
        bus1.mode = tm;
        clr1 = tc;
        exp_cnt1++;
        q1.push_back('{er, eo, es, exp_cnt1});
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        clr1 = 1'b0;
    endtask

    task automatic issue2(input logic [7:0] ta, input logic [7:0] tb, input mode_t tm, input logic tc,
                          input logic [15:0] er, input logic eo, input logic es);
        bus2.in_valid = 1'b1;
        bus2.a = ta;
        bus2.b = tb;
        bus2.mode = tm;
        clr2 = tc;
        exp_cnt2++;
        q2.push_back('{er, eo, es, exp_cnt2});
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        clr2 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q1.size() + q2.size()) != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(q1.size() + q2.size()), 0);
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_out_valid"}, 32'(bus1.out_valid), 0);
        chk({tag, "_result"}, 32'(bus1.result), 0);
        chk({tag, "_ovf"}, 32'(bus1.ovf), 0);
        chk({tag, "_sticky"}, 32'(sticky1), 0);
        chk({tag, "_count"}, 32'(cnt1), 0);
        chk({tag, "_in_ready"}, 32'(bus1.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_cnt1 = '0;
        exp_cnt2 = '0;
        rst_n = 1'b0;
        clr1 = 1'b0;
        clr2 = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.mode = MODE_ADD; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.mode = MODE_ADD; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_reset1("rst1");
        chk("rst2_out_valid", 32'(bus2.out_valid), 0);
        chk("rst2_result", 32'(bus2.result), 0);

        issue1(200, 100, MODE_ADD,    1'b0, 16'h012C, 1'b0, 1'b0);
        issue1(200, 100, MODE_SATADD, 1'b0, 16'd255,  1'b1, 1'b1);
        issue1(5,   7,   MODE_SUB,    1'b0, 16'hFFFE, 1'b1, 1'b1);
        issue1(7,   5,   MODE_SUB,    1'b0, 16'd2,    1'b0, 1'b1);
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        issue1(255, 255, MODE_ACC,    1'b0, 16'd510,  1'b0, 1'b0);
        issue1(255, 255, MODE_ACC,    1'b0, 16'd1020, 1'b0, 1'b0);
        issue1(255, 255, MODE_ACC,    1'b0, 16'd1530, 1'b0, 1'b0);
        issue1(1,   2,   MODE_ACC,    1'b1, 16'd3,    1'b0, 1'b0);
        issue1(0,   0,   MODE_ACC,    1'b0, 16'd3,    1'b0, 1'b0);
        issue1(1,   1,   MODE_ADD,    1'b0, 16'd2,    1'b0, 1'b0);
        issue1(1,   0,   MODE_ACC,    1'b0, 16'd4,    1'b0, 1'b0);
        issue1(255, 1,   MODE_SATADD, 1'b1, 16'd255,  1'b1, 1'b1);
        issue1(0,   0,   MODE_ADD,    1'b1, 16'd0,    1'b0, 1'b0);
        issue1(5,   5,   MODE_ACC,    1'b0, 16'd10,   1'b0, 1'b0);
        drain();

        issue2(255, 255, MODE_ACC, 1'b1, 16'd510, 1'b0, 1'b0);
        issue2(255, 255, MODE_ACC, 1'b0, 16'd508, 1'b1, 1'b1);
        issue2(2,   0,   MODE_ACC, 1'b0, 16'd510, 1'b0, 1'b1);
        drain();

        bus1.out_ready = 1'b0;
        issue1(10, 20, MODE_ADD, 1'b0, 16'd30, 1'b0, 1'b0);
        bus1.in_valid = 1'b1;
        bus1.a = 8'd1;
        bus1.b = 8'd1;
        bus1.mode = MODE_ADD;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(bus1.in_ready), 0);
            chk("stall_out_valid", 32'(bus1.out_valid), 1);
            chk("stall_result", 32'(bus1.result), 30);
            chk("stall_count", 32'(cnt1), 15);
        end
        @(posedge clk); #1;
        bus1.out_ready = 1'b1;
        exp_cnt1++;
        q1.push_back('{16'd2, 1'b0, 1'b0, exp_cnt1});
        #1 chk("resume_in_ready", 32'(bus1.in_ready), 1);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        chk("stall2_result", 32'(bus1.result), 2);
        chk("stall2_count", 32'(cnt1), 16);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q1.delete();
        exp_cnt1 = '0;
        chk_reset1("midrst");
        bus1.out_ready = 1'b1;

        for (int i = 0; i < 257; i++) begin
            logic [7:0] v;
            v = 8'(i);
            issue1(v, 8'd0, MODE_ADD, 1'b0, 16'(v), 1'b0, 1'b0);
        end
        drain();
        chk("cnt_final", 32'(cnt1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
